// File: rtl/idli_pkg.sv
// Shared types for the idli datapath: ALU/control op encodings, sequencer
// states, flag bit positions and the control-op decode used by the sequencer.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD,
    ALU_OP_AND,
    ALU_OP_OR,
    ALU_OP_XOR
  } alu_op_t;

  typedef enum logic [2:0] {
    CTL_OP_ADD,
    CTL_OP_ADC,
    CTL_OP_SUB,
    CTL_OP_SBC,
    CTL_OP_AND,
    CTL_OP_ANDN,
    CTL_OP_OR,
    CTL_OP_XOR
  } ctl_op_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_BUSY,
    SEQ_DONE
  } seq_state_t;

  // Flags are packed {N,Z,C,V}.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef struct packed {
    alu_op_t alu_op;
    logic    rhs_inv;
    logic    cin;
    logic    arith;
  } seq_dec_t;

  function automatic seq_dec_t ctl_decode(input ctl_op_t op, input logic cin);
    seq_dec_t d;
    d.alu_op  = ALU_OP_ADD;
    d.rhs_inv = 1'b0;
    d.cin     = 1'b0;
    d.arith   = 1'b1;
    unique case (op)
      CTL_OP_ADD:  ;
      CTL_OP_ADC:  d.cin = cin;
      CTL_OP_SUB:  begin d.rhs_inv = 1'b1; d.cin = 1'b1; end
      CTL_OP_SBC:  begin d.rhs_inv = 1'b1; d.cin = cin; end
      CTL_OP_AND:  begin d.alu_op = ALU_OP_AND; d.arith = 1'b0; end
      CTL_OP_ANDN: begin d.alu_op = ALU_OP_AND; d.rhs_inv = 1'b1; d.arith = 1'b0; end
      CTL_OP_OR:   begin d.alu_op = ALU_OP_OR;  d.arith = 1'b0; end
      CTL_OP_XOR:  begin d.alu_op = ALU_OP_XOR; d.arith = 1'b0; end
      default:     ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/idli_alu_m.sv
// 4-bit ALU slice: one nibble per use, with carry in/out and the carry into
// bit 3 so the caller can form signed overflow on the top nibble.
module idli_alu_m
  import idli_pkg::*;
(
  input  alu_op_t   i_alu_op,
  input  sqi_data_t i_alu_lhs,
  input  sqi_data_t i_alu_rhs,
  input  logic      i_alu_rhs_inv,
  input  logic      i_alu_cin,
  output sqi_data_t o_alu_data,
  output logic      o_alu_cout,
  output logic      o_alu_sign_cin
);

  sqi_data_t  w_rhs;
  logic [4:0] w_sum;
  logic [3:0] w_low;

  assign w_rhs = i_alu_rhs_inv ? ~i_alu_rhs : i_alu_rhs;
  assign w_sum = {1'b0, i_alu_lhs} + {1'b0, w_rhs} + {4'b0, i_alu_cin};
  // Sum of the low three bits; its MSB is the carry into the sign bit.
  assign w_low = {1'b0, i_alu_lhs[2:0]} + {1'b0, w_rhs[2:0]} + {3'b0, i_alu_cin};

  always_comb begin
    o_alu_data     = w_sum[3:0];
    o_alu_cout     = 1'b0;
    o_alu_sign_cin = 1'b0;
    unique case (i_alu_op)
      ALU_OP_ADD: begin
        o_alu_cout     = w_sum[4];
        o_alu_sign_cin = w_low[3];
      end
      ALU_OP_AND: o_alu_data = i_alu_lhs & w_rhs;
      ALU_OP_OR:  o_alu_data = i_alu_lhs | w_rhs;
      ALU_OP_XOR: o_alu_data = i_alu_lhs ^ w_rhs;
      default:    ;
    endcase
  end

endmodule

// File: rtl/idli_alu_seq_m.sv
// Sequencer that runs a full-width op through the 4-bit ALU one nibble per
// cycle (LSB first) and presents the result and NZCV flags on a handshake.
module idli_alu_seq_m
  import idli_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         i_seq_gck,
  input  logic         i_seq_rst_n,
  input  logic         i_seq_flush,
  input  logic         i_seq_in_vld,
  output logic         o_seq_in_rdy,
  input  ctl_op_t      i_seq_op,
  input  logic [W-1:0] i_seq_lhs,
  input  logic [W-1:0] i_seq_rhs,
  input  logic         i_seq_cin,
  output logic         o_seq_out_vld,
  input  logic         i_seq_out_rdy,
  output logic [W-1:0] o_seq_data,
  output logic [3:0]   o_seq_flags,
  output logic         o_seq_busy
);

  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  seq_state_t    r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_lhs, r_rhs, r_data;
  logic [3:0]    r_flags;
  alu_op_t       r_alu_op;
  logic          r_rhs_inv, r_arith;

  seq_dec_t      w_dec;
  logic          w_accept, w_last, w_step;
  logic [CW+1:0] w_idx;
  sqi_data_t     w_alu_data;
  logic          w_alu_cout, w_alu_sign_cin;
  logic [W-1:0]  w_data_next;
  logic [3:0]    w_flags;

  assign w_dec    = ctl_decode(i_seq_op, i_seq_cin);
  assign w_accept = i_seq_in_vld & o_seq_in_rdy;
  assign w_last   = (r_cnt == LAST);
  assign w_step   = (r_state == SEQ_BUSY) & ~i_seq_flush;
  assign w_idx    = {r_cnt, 2'b00};

  always_ff @(posedge i_seq_gck or negedge i_seq_rst_n) begin
    if (!i_seq_rst_n) r_state <= SEQ_IDLE;
    else              r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_seq_in_rdy = 1'b0;
    unique case (r_state)
      SEQ_IDLE: begin
        o_seq_in_rdy = 1'b1;
        if (i_seq_in_vld) w_state_next = SEQ_BUSY;
      end
      SEQ_BUSY: if (w_last) w_state_next = SEQ_DONE;
      SEQ_DONE: begin
        if (i_seq_out_rdy) begin
          o_seq_in_rdy = 1'b1;
          w_state_next = i_seq_in_vld ? SEQ_BUSY : SEQ_IDLE;
        end
      end
      default: w_state_next = SEQ_IDLE;
    endcase
    // Flush overrides both a new request and consumption of a held result.
    if (i_seq_flush) begin
      o_seq_in_rdy = 1'b0;
      w_state_next = SEQ_IDLE;
    end
  end

  idli_alu_m u_alu (
    .i_alu_op       (r_alu_op),
    .i_alu_lhs      (r_lhs[w_idx +: 4]),
    .i_alu_rhs      (r_rhs[w_idx +: 4]),
    .i_alu_rhs_inv  (r_rhs_inv),
    .i_alu_cin      (r_carry),
    .o_alu_data     (w_alu_data),
    .o_alu_cout     (w_alu_cout),
    .o_alu_sign_cin (w_alu_sign_cin)
  );

  always_comb begin
    w_data_next             = r_data;
    w_data_next[w_idx +: 4] = w_alu_data;
    w_flags                 = '0;
    w_flags[FLAG_N]         = w_data_next[W-1];
    w_flags[FLAG_Z]         = ~|w_data_next;
    w_flags[FLAG_C]         = r_arith & w_alu_cout;
    w_flags[FLAG_V]         = r_arith & (w_alu_sign_cin ^ w_alu_cout);
  end

  always_ff @(posedge i_seq_gck or negedge i_seq_rst_n) begin
    if (!i_seq_rst_n) begin
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_lhs     <= '0;
      r_rhs     <= '0;
      r_data    <= '0;
      r_flags   <= '0;
      r_alu_op  <= ALU_OP_ADD;
      r_rhs_inv <= 1'b0;
      r_arith   <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_carry   <= w_dec.cin;
      r_lhs     <= i_seq_lhs;
      r_rhs     <= i_seq_rhs;
      r_alu_op  <= w_dec.alu_op;
      r_rhs_inv <= w_dec.rhs_inv;
      r_arith   <= w_dec.arith;
    end else if (w_step) begin
      r_data  <= w_data_next;
      r_carry <= w_alu_cout;
      if (w_last) r_flags <= w_flags;
      else        r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_seq_out_vld = (r_state == SEQ_DONE);
  assign o_seq_busy    = (r_state == SEQ_BUSY);
  assign o_seq_data    = r_data;
  assign o_seq_flags   = r_flags;

endmodule

// File: tb/tb_idli_alu_seq_m.sv
// Directed and random checks of idli_alu_seq_m against an arithmetic
// reference model of the full-width ops.
module tb_idli_alu_seq_m;
  import idli_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_vld;
  logic         in_rdy;
  ctl_op_t      op_r;
  logic [W-1:0] lhs, rhs;
  logic         cin;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] o_data;
  logic [3:0]   o_flags;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idli_alu_seq_m #(.NIBBLES(4)) dut (
    .i_seq_gck     (clk),
    .i_seq_rst_n   (rst_n),
    .i_seq_flush   (flush),
    .i_seq_in_vld  (in_vld),
    .o_seq_in_rdy  (in_rdy),
    .i_seq_op      (op_r),
    .i_seq_lhs     (lhs),
    .i_seq_rhs     (rhs),
    .i_seq_cin     (cin),
    .o_seq_out_vld (out_vld),
    .i_seq_out_rdy (out_rdy),
    .o_seq_data    (o_data),
    .o_seq_flags   (o_flags),
    .o_seq_busy    (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic on integers; flags {N,Z,C,V}.
  function automatic void ref_op(input ctl_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, output logic [W-1:0] d, output logic [3:0] f);
    longint ua, ub, s;
    int     sa, sb, ss;
    bit     arith;
    logic [W-1:0] sa16, sb16;
    ua = longint'(a);
    ub = longint'(b);
    sa16 = a;
    sb16 = b;
    sa = int'($signed(sa16));
    sb = int'($signed(sb16));
    s = 0;
    ss = 0;
    d = '0;
    arith = 1'b1;
    case (op)
      CTL_OP_ADD: begin s = ua + ub;                        ss = sa + sb; end
      CTL_OP_ADC: begin s = ua + ub + longint'(c);          ss = sa + sb + int'(c); end
      CTL_OP_SUB: begin s = ua + (65536 - ub);              ss = sa - sb; end
      CTL_OP_SBC: begin s = ua + (65535 - ub) + longint'(c); ss = sa - sb - 1 + int'(c); end
      CTL_OP_AND:  begin d = a & b;  arith = 1'b0; end
      CTL_OP_ANDN: begin d = a & ~b; arith = 1'b0; end
      CTL_OP_OR:   begin d = a | b;  arith = 1'b0; end
      default:     begin d = a ^ b;  arith = 1'b0; end
    endcase
    if (arith) d = s[W-1:0];
    f[3] = d[W-1];
    f[2] = (d == '0);
    f[1] = arith && (s >= 65536);
    f[0] = arith && (ss > 32767 || ss < -32768);
  endfunction

  task automatic send(input ctl_op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    in_vld = 1'b1; op_r = op; lhs = a; rhs = b; cin = c;
    #1;
    while (!in_rdy && n < 20) begin tick; n++; end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    tick;
    // Operands only need to be valid in the accept cycle.
    in_vld = 1'b0;
    lhs = W'($urandom); rhs = W'($urandom); cin = 1'($urandom);
    op_r = ctl_op_t'($urandom_range(0, 7));
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_rdy_in_busy", 32'(in_rdy), 32'd0);
  endtask

  task automatic wait_done;
    int n = 0;
    while (!out_vld && n < 20) begin tick; n++; end
    chk("latency", n, 32'd4);
  endtask

  task automatic consume;
    out_rdy = 1'b1;
    #1;
    chk("in_rdy_on_consume", 32'(in_rdy), 32'd1);
    tick;
    out_rdy = 1'b0;
    chk("vld_after_consume", 32'(out_vld), 32'd0);
  endtask

  task automatic run_txn(input ctl_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int hold, input bit do_consume,
                         output logic [W-1:0] od, output logic [3:0] of);
    logic [W-1:0] ed;
    logic [3:0]   ef;
    ref_op(op, a, b, c, ed, ef);
    send(op, a, b, c);
    wait_done();
    od = o_data;
    of = o_flags;
    chk("data", 32'(o_data), 32'(ed));
    chk("flags", 32'(o_flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_vld", 32'(out_vld), 32'd1);
      chk("hold_data", 32'(o_data), 32'(ed));
      chk("hold_flags", 32'(o_flags), 32'(ef));
    end
    if (do_consume) consume();
    $display("txn op=%s lhs=%h rhs=%h cin=%0d data=%h flags=%b exp_data=%h exp_flags=%b",
             op.name(), a, b, c, od, of, ed, ef);
  endtask

  initial begin
    logic [W-1:0] od;
    logic [3:0]   of;
    int           seen;

    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; op_r = CTL_OP_ADD;
    lhs = '0; rhs = '0; cin = 1'b0; out_rdy = 1'b0;
    repeat (3) tick;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);

    run_txn(CTL_OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, od, of);
    chk("t1_data", 32'(od), 32'h8000);
    chk("t1_flags", 32'(of), 32'b1001);
    run_txn(CTL_OP_SUB, 16'h0005, 16'h0005, 1'b0, 0, 1'b1, od, of);
    chk("t2_data", 32'(od), 32'h0000);
    chk("t2_flags", 32'(of), 32'b0110);
    run_txn(CTL_OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 0, 1'b1, od, of);
    chk("t3a_data", 32'(od), 32'h0000);
    chk("t3a_flags", 32'(of), 32'b0110);
    run_txn(CTL_OP_SBC, 16'h0000, 16'h0001, 1'b1, 0, 1'b1, od, of);
    chk("t3b_data", 32'(od), 32'hFFFF);
    chk("t3b_flags", 32'(of), 32'b1000);

    // Held result, then back-to-back accept while consuming.
    run_txn(CTL_OP_ANDN, 16'hF0F0, 16'h00FF, 1'b0, 3, 1'b0, od, of);
    chk("t4_data", 32'(od), 32'hF000);
    chk("t4_flags", 32'(of), 32'b1000);
    out_rdy = 1'b1;
    send(CTL_OP_XOR, 16'h1234, 16'h00FF, 1'b0);
    out_rdy = 1'b0;
    chk("t4_b2b_vld", 32'(out_vld), 32'd0);
    wait_done();
    chk("t4_b2b_data", 32'(o_data), 32'h12CB);
    consume();
    $display("txn op=XOR back-to-back data=%h flags=%b", o_data, o_flags);

    // Flush mid-BUSY with the counter at 2.
    send(CTL_OP_ADD, 16'h1111, 16'h2222, 1'b0);
    tick;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    chk("flush_vld", 32'(out_vld), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_rdy", 32'(in_rdy), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick; if (out_vld) seen++; end
    chk("flush_no_vld", seen, 32'd0);
    $display("txn flush mid-busy");

    flush = 1'b1; in_vld = 1'b1; op_r = CTL_OP_ADD; lhs = 16'h0001; rhs = 16'h0001;
    #1;
    chk("flush_idle_in_rdy", 32'(in_rdy), 32'd0);
    tick;
    flush = 1'b0; in_vld = 1'b0;
    chk("flush_idle_no_accept", 32'(busy), 32'd0);
    $display("txn flush with in_vld in idle");

    // Reset mid-BUSY.
    send(CTL_OP_ADD, 16'h1111, 16'h1111, 1'b0);
    tick;
    rst_n = 1'b0;
    #1;
    chk("rstb_vld", 32'(out_vld), 32'd0);
    chk("rstb_busy", 32'(busy), 32'd0);
    chk("rstb_data", 32'(o_data), 32'd0);
    chk("rstb_flags", 32'(o_flags), 32'd0);
    rst_n = 1'b1;
    tick;
    $display("txn reset mid-busy");

    // Reset mid-DONE.
    send(CTL_OP_SUB, 16'h0003, 16'h0005, 1'b0);
    wait_done();
    rst_n = 1'b0;
    #1;
    chk("rstd_vld", 32'(out_vld), 32'd0);
    chk("rstd_busy", 32'(busy), 32'd0);
    chk("rstd_data", 32'(o_data), 32'd0);
    chk("rstd_flags", 32'(o_flags), 32'd0);
    rst_n = 1'b1;
    tick;
    $display("txn reset mid-done");

    run_txn(CTL_OP_ADD, 16'h0001, 16'h0002, 1'b0, 0, 1'b1, od, of);
    chk("t6_data", 32'(od), 32'h0003);

    for (int k = 0; k < 24; k++) begin
      run_txn(ctl_op_t'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)), 1'b1, od, of);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
